multicycle_control: RTL and testbench
=====================================

// Module: multicycle_control
// PURPOSE
//  Multicycle MIPS control unit: a Moore FSM that sequences fetch/decode/execute/mem/writeback.
//  Drives the shared-memory datapath (one ALU, IR, MDR, A/B, ALUOut).
//  Adds memory wait-state handshake, wait timeout, illegal-opcode trap and parametrised ALUOp width.
// PARAMETERS
//  ALUOP_WIDTH   3   alu_op width, >=3; codes below are zero-extended to this width
//  WAIT_TIMEOUT  15  max consecutive mem_ready=0 cycles in a memory state; 0 = no timeout
// PORTS
//  clk          in   1   rising-edge clock, single clock domain
//  reset        in   1   asynchronous, active-low reset
//  op           in   6   IR[31:26]; sampled in DECODE only
//  mem_ready    in   1   memory completes the current access this cycle
//  pc_write     out  1   unconditional PC load
//  pc_write_eq  out  1   PC load if ALU zero=1
//  pc_write_ne  out  1   PC load if ALU zero=0
//  iord         out  1   mem addr: 0=PC, 1=ALUOut
//  mem_read     out  1   memory read request
//  mem_write    out  1   memory write request
//  ir_write     out  1   IR load
//  reg_dst      out  2   00=rt 01=rd 10=$ra
//  mem_to_reg   out  2   00=ALUOut 01=MDR 10=PC
//  reg_write    out  1   register-file write
//  alu_src_a    out  1   0=PC 1=A
//  alu_src_b    out  2   00=B 01=const 4 10=imm 11=imm<<2
//  pc_source    out  2   00=ALU 01=ALUOut 10=jump target
//  alu_op       out  ALUOP_WIDTH  ALU function select
//  state        out  4   current state, for debug
//  illegal_op   out  1   sticky: unknown opcode decoded
//  mem_timeout  out  1   sticky: memory wait exceeded WAIT_TIMEOUT
// BEHAVIOUR
//  Reset: state=FETCH, wait counter=0, sticky flags=0; every output forced 0 while reset=0.
//  Outputs are decoded from state. ir_write/pc_write in FETCH are also gated by mem_ready.
//  Any output not listed for a state is 0.
//  States (encoding) / outputs / next state:
//   FETCH(0):    mem_read, iord=0, a=0, b=01, alu_op=010;
//                if mem_ready: ir_write, pc_write, ->DECODE; else stay.
//   DECODE(1):   a=0, b=11, alu_op=010.
//                op 00->R_EXEC; 23,2B->MEM_ADDR; 08,0C,0D,0F->I_EXEC; 04,05->BRANCH;
//                02->JUMP; 03->JAL (with macro only); else ->TRAP, set illegal_op.
//   MEM_ADDR(2): a=1, b=10, alu_op=010; op 23->MEM_RD, op 2B->MEM_WR.
//   MEM_RD(3):   mem_read, iord=1; if mem_ready ->MEM_WB; else stay.
//   MEM_WB(4):   reg_write, reg_dst=00, mem_to_reg=01 ->FETCH.
//   MEM_WR(5):   mem_write, iord=1; if mem_ready ->FETCH; else stay.
//   R_EXEC(6):   a=1, b=00, alu_op=111 ->R_WB.
//   R_WB(7):     reg_write, reg_dst=01, mem_to_reg=00 ->FETCH.
//   I_EXEC(10):  a=1, b=10; alu_op ADDI=110 ANDI=011 ORI=101 LUI=001 ->I_WB.
//   I_WB(11):    reg_write, reg_dst=00, mem_to_reg=00 ->FETCH.
//   BRANCH(8):   a=1, b=00, alu_op=100, pc_source=01;
//                pc_write_eq (op 04) or pc_write_ne (op 05) ->FETCH.
//   JUMP(9):     pc_write, pc_source=10 ->FETCH.
//   JAL(12):     pc_write, pc_source=10, reg_write, reg_dst=10, mem_to_reg=10 ->FETCH.
//   TRAP(15):    all strobes 0; held until reset.
//  Opcode is latched into an internal register in DECODE; later states use the latched copy.
//  Wait counter: counts cycles in FETCH/MEM_RD/MEM_WR with mem_ready=0; cleared on every state change.
//  Timeout: counter reaches WAIT_TIMEOUT -> TRAP and set mem_timeout, unless mem_ready=1 that cycle.
//  mem_ready=1 always wins over timeout. Counter saturates; width $clog2(WAIT_TIMEOUT+1).
//  Unused encodings 13,14 -> TRAP next cycle.
//  Reset mid-access drops all strobes immediately; no partial write is completed.
// CONFIGURATION
//  JAL_SUPPORT_EN defined: op 03 decodes to JAL, which writes PC (return address) to $ra.
//  Not defined: no JAL state is built; op 03 -> TRAP with illegal_op, like any unknown op.
// TESTING
//  R-type op=00, mem_ready=1 -> FETCH,DECODE,R_EXEC,R_WB; reg_write=1, reg_dst=01 in R_WB; 4 cycles.
//  LW op=23, ready low 3 cycles in MEM_RD -> mem_read/iord held 3 cycles; then MEM_WB, mem_to_reg=01.
//  BNE op=05 -> BRANCH with pc_write_ne=1, pc_write_eq=0, alu_op=100, pc_source=01; back to FETCH.
//  op=3F -> TRAP, illegal_op=1, all strobes 0 for 20 cycles; reset=0 -> state=0, flags cleared.
//  WAIT_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 cycles, mem_timeout=1.
//  Same setup, ready on cycle 4 -> DECODE, no timeout.
//  op=03: with JAL_SUPPORT_EN -> JAL, reg_dst=10, mem_to_reg=10; without -> TRAP, illegal_op=1.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Signal bundle between the multicycle control unit (master) and its datapath/memory side (slave).
interface multicycle_control_if #(
  parameter int ALUOP_WIDTH = 3
);
  logic [5:0]             op;
  logic                   mem_ready;
  logic                   pc_write;
  logic                   pc_write_eq;
  logic                   pc_write_ne;
  logic                   iord;
  logic                   mem_read;
  logic                   mem_write;
  logic                   ir_write;
  logic [1:0]             reg_dst;
  logic [1:0]             mem_to_reg;
  logic                   reg_write;
  logic                   alu_src_a;
  logic [1:0]             alu_src_b;
  logic [1:0]             pc_source;
  logic [ALUOP_WIDTH-1:0] alu_op;
  logic [3:0]             state;
  logic                   illegal_op;
  logic                   mem_timeout;

  modport master (
    input  op, mem_ready,
    output pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op,
           state, illegal_op, mem_timeout
  );

  modport slave (
    output op, mem_ready,
    input  pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write,
           reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source, alu_op,
           state, illegal_op, mem_timeout
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory wait states, wait timeout and illegal-opcode trap.
// Define JAL_SUPPORT_EN to build the JAL state (op 03); otherwise op 03 traps as illegal.
module multicycle_control #(
  parameter int ALUOP_WIDTH  = 3,
  parameter int WAIT_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  localparam int CW = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
`ifdef JAL_SUPPORT_EN
    JAL      = 4'd12,
`endif
    TRAP     = 4'd15
  } state_t;

  state_t          state_q, state_d;
  logic [5:0]      op_q;
  logic [CW-1:0]   wait_q;
  logic            illegal_q, timeout_q;
  logic            waiting, set_illegal, set_timeout, timeout_hit;

  // The WAIT_TIMEOUT-th consecutive not-ready cycle is the last one tolerated.
  assign timeout_hit = (WAIT_TIMEOUT != 0) && (int'(wait_q) >= WAIT_TIMEOUT - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      op_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.op;
      if (state_d != state_q)            wait_q <= '0;
      else if (waiting && wait_q != '1)  wait_q <= wait_q + CW'(1);
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
    end
  end

  always_comb begin
    state_d         = state_q;
    waiting         = 1'b0;
    set_illegal     = 1'b0;
    set_timeout     = 1'b0;
    bus.pc_write    = 1'b0;
    bus.pc_write_eq = 1'b0;
    bus.pc_write_ne = 1'b0;
    bus.iord        = 1'b0;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.ir_write    = 1'b0;
    bus.reg_dst     = 2'b00;
    bus.mem_to_reg  = 2'b00;
    bus.reg_write   = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.pc_source   = 2'b00;
    bus.alu_op      = '0;
    bus.state       = state_q;
    bus.illegal_op  = illegal_q;
    bus.mem_timeout = timeout_q;

    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_op    = ALUOP_WIDTH'(3'b010);
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      DECODE: begin
        bus.alu_src_b = 2'b11;
        bus.alu_op    = ALUOP_WIDTH'(3'b010);
        case (bus.op)
          6'h00:                      state_d = R_EXEC;
          6'h23, 6'h2B:               state_d = MEM_ADDR;
          6'h08, 6'h0C, 6'h0D, 6'h0F: state_d = I_EXEC;
          6'h04, 6'h05:               state_d = BRANCH;
          6'h02:                      state_d = JUMP;
`ifdef JAL_SUPPORT_EN
          6'h03:                      state_d = JAL;
`endif
          default: begin
            state_d     = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_op    = ALUOP_WIDTH'(3'b010);
        state_d       = (op_q == 6'h23) ? MEM_RD : (op_q == 6'h2B) ? MEM_WR : TRAP;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
        if (bus.mem_ready) state_d = MEM_WB;
        else               waiting = 1'b1;
      end
      MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 2'b01;
        state_d        = FETCH;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
        else               waiting = 1'b1;
      end
      R_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = ALUOP_WIDTH'(3'b111);
        state_d       = R_WB;
      end
      R_WB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 2'b01;
        state_d       = FETCH;
      end
      I_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        case (op_q)
          6'h08:   bus.alu_op = ALUOP_WIDTH'(3'b110);
          6'h0C:   bus.alu_op = ALUOP_WIDTH'(3'b011);
          6'h0D:   bus.alu_op = ALUOP_WIDTH'(3'b101);
          default: bus.alu_op = ALUOP_WIDTH'(3'b001);
        endcase
        state_d = I_WB;
      end
      I_WB: begin
        bus.reg_write = 1'b1;
        state_d       = FETCH;
      end
      BRANCH: begin
        bus.alu_src_a   = 1'b1;
        bus.alu_op      = ALUOP_WIDTH'(3'b100);
        bus.pc_source   = 2'b01;
        bus.pc_write_eq = (op_q == 6'h04);
        bus.pc_write_ne = (op_q == 6'h05);
        state_d         = FETCH;
      end
      JUMP: begin
        bus.pc_write  = 1'b1;
        bus.pc_source = 2'b10;
        state_d       = FETCH;
      end
`ifdef JAL_SUPPORT_EN
      JAL: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = 2'b10;
        bus.reg_write  = 1'b1;
        bus.reg_dst    = 2'b10;
        bus.mem_to_reg = 2'b10;
        state_d        = FETCH;
      end
`endif
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase

    // mem_ready=1 takes precedence: waiting is only set on not-ready cycles.
    if (waiting && timeout_hit) begin
      state_d     = TRAP;
      set_timeout = 1'b1;
    end

    // Outputs are held low for as long as reset is asserted.
    if (!reset) begin
      bus.pc_write    = 1'b0;
      bus.pc_write_eq = 1'b0;
      bus.pc_write_ne = 1'b0;
      bus.iord        = 1'b0;
      bus.mem_read    = 1'b0;
      bus.mem_write   = 1'b0;
      bus.ir_write    = 1'b0;
      bus.reg_dst     = 2'b00;
      bus.mem_to_reg  = 2'b00;
      bus.reg_write   = 1'b0;
      bus.alu_src_a   = 1'b0;
      bus.alu_src_b   = 2'b00;
      bus.pc_source   = 2'b00;
      bus.alu_op      = '0;
      bus.state       = 4'd0;
      bus.illegal_op  = 1'b0;
      bus.mem_timeout = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction phase model feeds a queue
// of expected per-cycle outputs; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam int AW = 4;
  localparam int WT = 4;

  typedef struct packed {
    logic          pc_write, pc_write_eq, pc_write_ne, iord, mem_read, mem_write, ir_write;
    logic [1:0]    reg_dst, mem_to_reg;
    logic          reg_write, alu_src_a;
    logic [1:0]    alu_src_b, pc_source;
    logic [AW-1:0] alu_op;
    logic [3:0]    state;
    logic          illegal_op, mem_timeout;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_if #(.ALUOP_WIDTH(AW)) bus ();

  multicycle_control #(.ALUOP_WIDTH(AW), .WAIT_TIMEOUT(WT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    ill_m  = 1'b0;
  bit    to_m   = 1'b0;
  int    trap_len = 20;

  function automatic obs_t sample();
    obs_t s;
    s.pc_write = bus.pc_write;   s.pc_write_eq = bus.pc_write_eq; s.pc_write_ne = bus.pc_write_ne;
    s.iord = bus.iord;           s.mem_read = bus.mem_read;       s.mem_write = bus.mem_write;
    s.ir_write = bus.ir_write;   s.reg_dst = bus.reg_dst;         s.mem_to_reg = bus.mem_to_reg;
    s.reg_write = bus.reg_write; s.alu_src_a = bus.alu_src_a;     s.alu_src_b = bus.alu_src_b;
    s.pc_source = bus.pc_source; s.alu_op = bus.alu_op;           s.state = bus.state;
    s.illegal_op = bus.illegal_op; s.mem_timeout = bus.mem_timeout;
    return s;
  endfunction

  // Reference: output table of each phase of the instruction flow, keyed by phase number.
  function automatic obs_t expect_out(int ph, logic [5:0] opl, bit rdy);
    obs_t o = '0;
    o.state       = 4'(ph);
    o.illegal_op  = ill_m;
    o.mem_timeout = to_m;
    case (ph)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_op = AW'(2); o.ir_write = rdy; o.pc_write = rdy; end
      1:  begin o.alu_src_b = 2'b11; o.alu_op = AW'(2); end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_op = AW'(2); end
      3:  begin o.mem_read = 1; o.iord = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 2'b01; end
      5:  begin o.mem_write = 1; o.iord = 1; end
      6:  begin o.alu_src_a = 1; o.alu_op = AW'(7); end
      7:  begin o.reg_write = 1; o.reg_dst = 2'b01; end
      8:  begin
            o.alu_src_a = 1; o.alu_op = AW'(4); o.pc_source = 2'b01;
            o.pc_write_eq = (opl == 6'h04); o.pc_write_ne = (opl == 6'h05);
          end
      9:  begin o.pc_write = 1; o.pc_source = 2'b10; end
      10: begin
            o.alu_src_a = 1; o.alu_src_b = 2'b10;
            o.alu_op = (opl == 6'h08) ? AW'(6) : (opl == 6'h0C) ? AW'(3) :
                       (opl == 6'h0D) ? AW'(5) : AW'(1);
          end
      11: o.reg_write = 1;
      12: begin o.pc_write = 1; o.pc_source = 2'b10; o.reg_write = 1; o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic push_cycle(obs_t e, string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    bus.op = 6'($urandom);
  endtask

  task automatic step(int ph, logic [5:0] opl, bit rdy);
    bus.mem_ready = rdy;
    push_cycle(expect_out(ph, opl, rdy), $sformatf("op%02h_st%0d", opl, ph));
  endtask

  // Memory phase with w not-ready cycles; returns 1 if the wait timed out.
  task automatic mem_phase(int ph, logic [5:0] opl, int w, output bit timed_out);
    timed_out = 1'b0;
    for (int i = 0; ; i++) begin
      step(ph, opl, i >= w);
      if (i >= w) break;
      if (i + 1 == WT) begin timed_out = 1'b1; break; end
    end
  endtask

  task automatic do_reset(int n);
    reset = 1'b0;
    ill_m = 1'b0;
    to_m  = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.mem_ready = 1'($urandom);
      push_cycle('0, "reset");
    end
    reset = 1'b1;
  endtask

  task automatic trap_and_reset(logic [5:0] opl);
    for (int i = 0; i < trap_len; i++) step(15, opl, 1'($urandom));
    do_reset(2);
  endtask

  task automatic run_instr(logic [5:0] op, int wf, int wm);
    bit t;
    mem_phase(0, op, wf, t);
    if (t) begin to_m = 1'b1; trap_and_reset(op); return; end
    bus.op = op;
    step(1, op, 1'($urandom));
    case (op)
      6'h00: begin step(6, op, 1'($urandom)); step(7, op, 1'($urandom)); end
      6'h23: begin
        step(2, op, 1'($urandom));
        mem_phase(3, op, wm, t);
        if (t) begin to_m = 1'b1; trap_and_reset(op); return; end
        step(4, op, 1'($urandom));
      end
      6'h2B: begin
        step(2, op, 1'($urandom));
        mem_phase(5, op, wm, t);
        if (t) begin to_m = 1'b1; trap_and_reset(op); return; end
      end
      6'h08, 6'h0C, 6'h0D, 6'h0F: begin step(10, op, 1'($urandom)); step(11, op, 1'($urandom)); end
      6'h04, 6'h05: step(8, op, 1'($urandom));
      6'h02: step(9, op, 1'($urandom));
`ifdef JAL_SUPPORT_EN
      6'h03: step(12, op, 1'($urandom));
`endif
      default: begin ill_m = 1'b1; trap_and_reset(op); end
    endcase
  endtask

  always @(negedge clk) begin
    obs_t e;
    obs_t g;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = sample();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s got=%h exp=%h", t, g, e);
      end
    end
  end

  function automatic int rand_wait();
    return ($urandom_range(0, 7) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [5:0] ops [11];
    logic [5:0] op;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h04, 6'h05, 6'h02, 6'h03};
    bus.op = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(6'h00, 0, 0);
    run_instr(6'h23, 0, 3);
    run_instr(6'h05, 1, 0);
    run_instr(6'h04, 0, 0);
    run_instr(6'h3F, 0, 0);
    run_instr(6'h00, 4, 0);
    run_instr(6'h00, 3, 0);
    run_instr(6'h03, 0, 0);
    run_instr(6'h2B, 0, 2);
    run_instr(6'h2B, 0, 4);
    run_instr(6'h23, 2, 4);
    run_instr(6'h0D, 0, 0);

    for (int n = 0; n < 120; n++) begin
      trap_len = int'($urandom_range(2, 6));
      if ($urandom_range(0, 11) == 11) op = 6'($urandom);
      else                             op = ops[$urandom_range(0, 10)];
      run_instr(op, rand_wait(), rand_wait());
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
